// File: rtl/clk_time_writer_pkg.sv
// Shared constants and state encoding for the RTC set-interface writer and its field checker.
package clk_time_writer_pkg;

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;
    localparam logic [1:0] ADDR_HOUR = 2'b10;

    localparam int unsigned MAX_SEC  = 59;
    localparam int unsigned MAX_MIN  = 59;
    localparam int unsigned MAX_HOUR = 23;

    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StGap   = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } wr_state_e;

endpackage

// File: rtl/clk_field_check.sv
// Combinational range check of the masked time fields; valid=1 when every selected field is legal.
module clk_field_check
    import clk_time_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 6
) (
    input  logic [2:0]        mask,
    input  logic [DATA_W-1:0] sec_val,
    input  logic [DATA_W-1:0] min_val,
    input  logic [DATA_W-1:0] hour_val,
    output logic              valid
);

    logic sec_ok;
    logic min_ok;
    logic hour_ok;

    // Unselected fields never cause a rejection.
    always_comb begin
        sec_ok  = !mask[0] || (sec_val  <= DATA_W'(MAX_SEC));
        min_ok  = !mask[1] || (min_val  <= DATA_W'(MAX_MIN));
        hour_ok = !mask[2] || (hour_val <= DATA_W'(MAX_HOUR));
        valid   = sec_ok && min_ok && hour_ok;
    end

endmodule

// File: rtl/clk_time_writer.sv
// Issues one load write per selected time field to the RTC, spaced by GAP_CYCLES idle cycles.
module clk_time_writer
    import clk_time_writer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned DATA_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mask,
    input  logic [DATA_W-1:0] sec_in,
    input  logic [DATA_W-1:0] min_in,
    input  logic [DATA_W-1:0] hour_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              load,
    output logic [1:0]        addrs,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    wr_state_e state_q, state_d;
    logic [2:0]           pend_q, pend_d;
    logic [DATA_W-1:0]    sec_q, sec_d;
    logic [DATA_W-1:0]    min_q, min_d;
    logic [DATA_W-1:0]    hour_q, hour_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 load_q, load_d;
    logic [1:0]           addrs_q, addrs_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 cmd_valid;

    clk_field_check #(
        .DATA_W (DATA_W)
    ) u_field_check (
        .mask     (mask),
        .sec_val  (sec_in),
        .min_val  (min_in),
        .hour_val (hour_in),
        .valid    (cmd_valid)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_d  = 1'b0;
        addrs_d = addrs_q;
        data_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!cmd_valid) begin
                        state_d = StErr;
                    end else begin
                        sec_d   = sec_in;
                        min_d   = min_in;
                        hour_d  = hour_in;
                        pend_d  = mask;
                        busy_d  = 1'b1;
                        state_d = (mask == 3'b000) ? StDone : StIssue;
                    end
                end
            end
            StIssue: begin
                // Fixed priority: seconds, then minutes, then hours.
                load_d  = 1'b1;
                gap_d   = GAP_LOAD;
                state_d = StGap;
                if (pend_q[0]) begin
                    addrs_d   = ADDR_SEC;
                    data_d    = sec_q;
                    pend_d[0] = 1'b0;
                end else if (pend_q[1]) begin
                    addrs_d   = ADDR_MIN;
                    data_d    = min_q;
                    pend_d[1] = 1'b0;
                end else begin
                    addrs_d   = ADDR_HOUR;
                    data_d    = hour_q;
                    pend_d[2] = 1'b0;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = (pend_q != 3'b000) ? StIssue : StDone;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            pend_q  <= 3'b000;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            addrs_q <= ADDR_SEC;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
            addrs_q <= addrs_d;
            data_q  <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign load     = load_q;
    assign addrs    = addrs_q;
    assign data_out = data_q;

endmodule
